cdda_stream_fifo: RTL and testbench

//  Parametrised CD-audio stream buffer between the CD sector data path and the audio mixer.
//  - Collects CHANNELS serial SAMPLE_W-bit words per frame from WRITE strobes and stores whole frames in a DEPTH-frame circular RAM.
//  - Pops one frame per READ (sample-rate) strobe.
//  - Adds flush, mute, a selectable underrun policy, overflow/underrun reporting and a level output.

---
 rtl/cdda_stream_fifo_if.sv | 29 ++
 rtl/cdda_stream_fifo.sv | 115 +++++++++++
 tb/tb_cdda_stream_fifo.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cdda_stream_fifo_if.sv
// cdda_stream_fifo_if: strobe, frame and status bundle between the CD data path, the mixer and the stream buffer
interface cdda_stream_fifo_if #(
    parameter int SAMPLE_W = 16,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 2048
);
    localparam int LW = $clog2(DEPTH + 1);
    logic                         WRITE;
    logic [SAMPLE_W-1:0]          DIN;
    logic                         READ;
    logic                         FLUSH;
    logic                         MUTE;
    logic                         WRITE_READY;
    logic                         EMPTY;
    logic                         FULL;
    logic [LW-1:0]                LEVEL;
    logic                         OVERFLOW;
    logic [7:0]                   UNDERRUN_CNT;
    logic [CHANNELS*SAMPLE_W-1:0] AUDIO_OUT;
    logic                         SAMPLE_VALID;
    modport master (
        output WRITE, DIN, READ, FLUSH, MUTE,
        input  WRITE_READY, EMPTY, FULL, LEVEL, OVERFLOW, UNDERRUN_CNT, AUDIO_OUT, SAMPLE_VALID
    );
    modport slave (
        input  WRITE, DIN, READ, FLUSH, MUTE,
        output WRITE_READY, EMPTY, FULL, LEVEL, OVERFLOW, UNDERRUN_CNT, AUDIO_OUT, SAMPLE_VALID
    );
endinterface

// File: rtl/cdda_stream_fifo.sv
// cdda_stream_fifo: assembles serial samples into frames, buffers them in a circular RAM and pops one frame per sample strobe
module cdda_stream_fifo #(
    parameter int SAMPLE_W      = 16,
    parameter int CHANNELS      = 2,
    parameter int DEPTH         = 2048,
    parameter int SECTOR_FRAMES = 588,
    parameter int UNDERRUN_HOLD = 0
) (
    input logic               CLK,
    input logic               RESET,
    cdda_stream_fifo_if.slave bus
);
    localparam int CW = CHANNELS * SAMPLE_W;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int XW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    logic          write_q, read_q, write_ce, read_ce;
    logic [XW-1:0] ch;
    logic [CW-1:0] slots, commit_frame, pend_frame, rd_data, last_frame, audio;
    logic          pend, overflow, push, pop, under, empty, full, v1, u1, valid;
    logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [LW-1:0] level;
    logic [7:0]    ucnt;
    logic [CW-1:0] mem [DEPTH];
    // strobe edges, flag decode, pointer wrap and the frame being committed (newest word in the top slot)
    always_comb begin
        write_ce = bus.WRITE & ~write_q;
        read_ce  = bus.READ & ~read_q;
        empty    = level == '0;
        full     = level == LW'(DEPTH);
        push     = pend & ~bus.FLUSH & ~RESET;
        pop      = read_ce & ~empty & ~bus.FLUSH;
        under    = read_ce & (empty | bus.FLUSH);
        wr_nxt   = wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
        rd_nxt   = rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
        commit_frame = slots;
        commit_frame[(CHANNELS-1)*SAMPLE_W +: SAMPLE_W] = bus.DIN;
    end
    assign bus.EMPTY        = empty;
    assign bus.FULL         = full;
    assign bus.LEVEL        = level;
    assign bus.WRITE_READY  = level <= LW'(DEPTH - SECTOR_FRAMES);
    assign bus.OVERFLOW     = overflow;
    assign bus.UNDERRUN_CNT = ucnt;
    assign bus.AUDIO_OUT    = audio;
    assign bus.SAMPLE_VALID = valid;
    // previous strobe levels so a held strobe acts only once
    always_ff @(posedge CLK) begin
        if (RESET) begin
            write_q <= 1'b0;
            read_q  <= 1'b0;
        end else begin
            write_q <= bus.WRITE;
            read_q  <= bus.READ;
        end
    end
    // collect words into slots; the last word commits the frame, or drops it and flags overflow when full
    always_ff @(posedge CLK) begin
        if (RESET || bus.FLUSH) begin
            ch       <= '0;
            pend     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            pend <= 1'b0;
            if (write_ce) begin
                slots[ch*SAMPLE_W +: SAMPLE_W] <= bus.DIN;
                if (ch == XW'(CHANNELS - 1)) begin
                    ch         <= '0;
                    pend       <= ~full;
                    pend_frame <= commit_frame;
                    if (full) overflow <= 1'b1;
                end else begin
                    ch <= ch + 1'b1;
                end
            end
        end
    end
    // frame RAM: one write port, one registered read port
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= pend_frame;
        if (pop) rd_data <= mem[rd_ptr];
    end
    // circular pointers and stored-frame count
    always_ff @(posedge CLK) begin
        if (RESET || bus.FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_nxt;
            if (pop) rd_ptr <= rd_nxt;
            level <= level + LW'(push) - LW'(pop);
        end
    end
    // second read stage: present popped, held or silent frame two cycles after the strobe and count underruns
    always_ff @(posedge CLK) begin
        if (RESET) begin
            v1         <= 1'b0;
            u1         <= 1'b0;
            valid      <= 1'b0;
            audio      <= '0;
            last_frame <= '0;
            ucnt       <= '0;
        end else begin
            v1    <= read_ce;
            u1    <= under;
            valid <= v1;
            if (v1) begin
                audio <= bus.MUTE ? '0 : !u1 ? rd_data : UNDERRUN_HOLD != 0 ? last_frame : '0;
                if (!u1) last_frame <= rd_data;
            end
            if (under && ucnt != 8'hFF) ucnt <= ucnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_cdda_stream_fifo.sv
// tb_cdda_stream_fifo: directed checks of framing, levels, flags, underrun policies, flush and mute on three configurations
module tb_cdda_stream_fifo;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int total = 0;
    int bad = 0;
    logic [31:0] q[$];
    logic [143:0] exp_b;
    always #5 CLK = ~CLK;
    cdda_stream_fifo_if #(.SAMPLE_W(16), .CHANNELS(2), .DEPTH(2048)) i0 ();
    cdda_stream_fifo_if #(.SAMPLE_W(16), .CHANNELS(2), .DEPTH(5)) i1 ();
    cdda_stream_fifo_if #(.SAMPLE_W(24), .CHANNELS(6), .DEPTH(8)) i2 ();
    cdda_stream_fifo #(.SAMPLE_W(16), .CHANNELS(2), .DEPTH(2048), .SECTOR_FRAMES(588), .UNDERRUN_HOLD(0))
        u0 (.CLK(CLK), .RESET(RESET), .bus(i0));
    cdda_stream_fifo #(.SAMPLE_W(16), .CHANNELS(2), .DEPTH(5), .SECTOR_FRAMES(2), .UNDERRUN_HOLD(1))
        u1 (.CLK(CLK), .RESET(RESET), .bus(i1));
    cdda_stream_fifo #(.SAMPLE_W(24), .CHANNELS(6), .DEPTH(8), .SECTOR_FRAMES(4), .UNDERRUN_HOLD(0))
        u2 (.CLK(CLK), .RESET(RESET), .bus(i2));
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask
    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic wr(input int u, input logic [23:0] d);
        i0.DIN = d[15:0];
        i1.DIN = d[15:0];
        i2.DIN = d;
        i0.WRITE = (u == 0);
        i1.WRITE = (u == 1);
        i2.WRITE = (u == 2);
        tick;
        i0.WRITE = 1'b0;
        i1.WRITE = 1'b0;
        i2.WRITE = 1'b0;
        tick;
    endtask
    task automatic rd(input int u);
        i0.READ = (u == 0);
        i1.READ = (u == 1);
        i2.READ = (u == 2);
        tick;
        i0.READ = 1'b0;
        i1.READ = 1'b0;
        i2.READ = 1'b0;
        tick;
    endtask
    function automatic logic [31:0] fr(input int f);
        logic [15:0] l;
        l = 16'(f);
        return {l + 16'h1000, l};
    endfunction
    task automatic wf(input int u, input int f);
        logic [31:0] v;
        v = fr(f);
        wr(u, {8'h00, v[15:0]});
        wr(u, {8'h00, v[31:16]});
    endtask
    initial begin
        i0.WRITE = 0; i0.DIN = '0; i0.READ = 0; i0.FLUSH = 0; i0.MUTE = 0;
        i1.WRITE = 0; i1.DIN = '0; i1.READ = 0; i1.FLUSH = 0; i1.MUTE = 0;
        i2.WRITE = 0; i2.DIN = '0; i2.READ = 0; i2.FLUSH = 0; i2.MUTE = 0;
        tick;
        tick;
        RESET = 1'b0;
        tick;
        chk("rst_flags", {i0.EMPTY, i0.WRITE_READY, i0.FULL, i0.OVERFLOW, i0.SAMPLE_VALID}, 5'b11000);
        chk("rst_level", i0.LEVEL, 0);
        chk("rst_ucnt", i0.UNDERRUN_CNT, 0);
        chk("rst_audio", i0.AUDIO_OUT, 0);
        chk("rst_c_flags", {i2.EMPTY, i2.WRITE_READY, i2.LEVEL}, {2'b11, 4'd0});
        // two frames then two reads with the fixed two-cycle latency
        wr(0, 24'h1111);
        wr(0, 24'h2222);
        wr(0, 24'h3333);
        wr(0, 24'h4444);
        chk("t1_level2", i0.LEVEL, 2);
        i0.READ = 1'b1;
        tick;
        i0.READ = 1'b0;
        chk("t1_latency", {i0.SAMPLE_VALID, i0.LEVEL}, {1'b0, 12'd1});
        tick;
        chk("t1_frame0", {i0.SAMPLE_VALID, i0.AUDIO_OUT}, {1'b1, 32'h2222_1111});
        tick;
        chk("t1_pulse", i0.SAMPLE_VALID, 0);
        rd(0);
        chk("t1_frame1", i0.AUDIO_OUT, 32'h4444_3333);
        chk("t1_empty", {i0.EMPTY, i0.LEVEL}, {1'b1, 12'd0});
        // underrun with zero policy
        rd(0);
        chk("t3_zero_audio", {i0.SAMPLE_VALID, i0.AUDIO_OUT}, {1'b1, 32'h0});
        chk("t3_ucnt1", i0.UNDERRUN_CNT, 1);
        // thresholds, full and overflow
        for (int f = 0; f < 1460; f++) wf(0, f);
        chk("t2_1460", {i0.LEVEL, i0.WRITE_READY}, {12'd1460, 1'b1});
        wf(0, 1460);
        chk("t2_1461", {i0.LEVEL, i0.WRITE_READY}, {12'd1461, 1'b0});
        for (int f = 1461; f < 2048; f++) wf(0, f);
        chk("t2_full", {i0.LEVEL, i0.FULL, i0.OVERFLOW}, {12'd2048, 1'b1, 1'b0});
        wf(0, 2048);
        chk("t2_overflow", {i0.LEVEL, i0.FULL, i0.OVERFLOW}, {12'd2048, 1'b1, 1'b1});
        rd(0);
        chk("t2_first_frame", i0.AUDIO_OUT, 32'h1000_0000);
        chk("t2_after_pop", {i0.LEVEL, i0.FULL}, {12'd2047, 1'b0});
        // flush with half a frame assembled
        wr(0, 24'h1234);
        i0.FLUSH = 1'b1;
        tick;
        i0.FLUSH = 1'b0;
        chk("t5_flush_flags", {i0.LEVEL, i0.EMPTY, i0.OVERFLOW, i0.WRITE_READY}, {12'd0, 1'b1, 1'b0, 1'b1});
        chk("t5_keep", {i0.UNDERRUN_CNT, i0.AUDIO_OUT}, {8'd1, 32'h1000_0000});
        wr(0, 24'hAAAA);
        wr(0, 24'hBBBB);
        rd(0);
        chk("t5_aligned", i0.AUDIO_OUT, 32'hBBBB_AAAA);
        // saturating underrun counter
        for (int k = 0; k < 300; k++) rd(0);
        chk("t3_saturate", {i0.UNDERRUN_CNT, i0.AUDIO_OUT}, {8'd255, 32'h0});
        // a write strobe held high captures one word only
        i0.DIN = 16'h7777;
        i0.WRITE = 1'b1;
        tick;
        tick;
        tick;
        i0.WRITE = 1'b0;
        tick;
        wr(0, 24'h8888);
        chk("held_write_level", i0.LEVEL, 1);
        rd(0);
        chk("held_write_frame", i0.AUDIO_OUT, 32'h8888_7777);
        // reset in the middle of a frame
        wr(0, 24'h0F0F);
        RESET = 1'b1;
        tick;
        RESET = 1'b0;
        chk("midrst_state", {i0.UNDERRUN_CNT, i0.LEVEL, i0.EMPTY, i0.WRITE_READY}, {8'd0, 12'd0, 1'b1, 1'b1});
        chk("midrst_audio", i0.AUDIO_OUT, 0);
        wr(0, 24'h0001);
        wr(0, 24'h0002);
        rd(0);
        chk("midrst_aligned", i0.AUDIO_OUT, 32'h0002_0001);
        // hold policy: muted pop still records the last good frame
        wr(1, 24'h5555);
        wr(1, 24'h6666);
        i1.MUTE = 1'b1;
        rd(1);
        i1.MUTE = 1'b0;
        chk("t3_mute_pop", {i1.SAMPLE_VALID, i1.AUDIO_OUT, i1.LEVEL}, {1'b1, 32'h0, 3'd0});
        rd(1);
        chk("t3_hold", {i1.SAMPLE_VALID, i1.AUDIO_OUT}, {1'b1, 32'h6666_5555});
        chk("t3_hold_ucnt", i1.UNDERRUN_CNT, 1);
        // small depth: simultaneous push and pop across several pointer wraps
        wf(1, 100);
        wf(1, 101);
        q.push_back(fr(100));
        q.push_back(fr(101));
        for (int k = 0; k < 12; k++) begin
            logic [31:0] v, e;
            v = fr(102 + k);
            wr(1, {8'h00, v[15:0]});
            i1.DIN = v[31:16];
            i1.WRITE = 1'b1;
            tick;
            i1.WRITE = 1'b0;
            i1.READ = 1'b1;
            tick;
            i1.READ = 1'b0;
            q.push_back(v);
            e = q.pop_front();
            chk("t4_level", i1.LEVEL, 2);
            tick;
            chk("t4_order", i1.AUDIO_OUT, e);
        end
        // wide frames with mute
        for (int k = 0; k < 6; k++) wr(2, 24'hA00000 + 24'(k));
        for (int k = 0; k < 6; k++) wr(2, 24'hB00000 + 24'(k));
        chk("t6_level2", i2.LEVEL, 2);
        i2.MUTE = 1'b1;
        rd(2);
        i2.MUTE = 1'b0;
        chk("t6_muted", {i2.SAMPLE_VALID, i2.AUDIO_OUT, i2.LEVEL}, {1'b1, 144'h0, 4'd1});
        exp_b = '0;
        for (int k = 0; k < 6; k++) exp_b[k*24 +: 24] = 24'hB00000 + 24'(k);
        rd(2);
        chk("t6_second", i2.AUDIO_OUT, exp_b);
        chk("t6_empty", {i2.LEVEL, i2.EMPTY}, {4'd0, 1'b1});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
